// File: rtl/mem_access_stage_pkg.sv
// Shared types and defaults for the MIPS MEM stage (mem_access_stage) and its MEM/WB register.
package mem_stage_pkg;

    localparam int unsigned ADDR_W_DEF         = 10;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic regWrite;
        logic memToReg;
    } wb_ctrl_t;

    localparam wb_ctrl_t WB_BUBBLE = '{regWrite: 1'b0, memToReg: 1'b0};

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the data memory (slave).
interface mem_access_stage_if
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic [31:0]       dmem_rdata;
    logic              dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_access_stage_mem_wb_reg.sv
// MEM/WB pipeline register: loads a bubble while stalled, captures load data only when told to.
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_stall,
    input  logic        i_rdLoad,
    input  logic [31:0] i_rdData,
    input  logic [31:0] i_aluResult,
    input  logic [4:0]  i_destReg,
    input  wb_ctrl_t    i_ctrl,
    output logic [31:0] o_readData,
    output logic [31:0] o_aluResult,
    output logic [4:0]  o_destReg,
    output wb_ctrl_t    o_ctrl
);
    logic [31:0] r_readData;
    logic [31:0] r_aluResult;
    logic [4:0]  r_destReg;
    wb_ctrl_t    r_ctrl;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_readData  <= '0;
            r_aluResult <= '0;
            r_destReg   <= '0;
            r_ctrl      <= WB_BUBBLE;
        end else if (i_stall) begin
            // data fields hold so a bubble never disturbs forwarding values
            r_ctrl <= WB_BUBBLE;
        end else begin
            r_aluResult <= i_aluResult;
            r_destReg   <= i_destReg;
            r_ctrl      <= i_ctrl;
            if (i_rdLoad) begin
                r_readData <= i_rdData;
            end
        end
    end

    assign o_readData  = r_readData;
    assign o_aluResult = r_aluResult;
    assign o_destReg   = r_destReg;
    assign o_ctrl      = r_ctrl;
endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: variable-latency data-memory access FSM, stall/branch resolution, MEM/WB register.
// Optional access timeout with sticky memErr enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_W         = ADDR_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        inPcBranch,
    input  logic               inZeroFlag,
    input  logic [31:0]        inAluResult,
    input  logic [31:0]        inWriteData,
    input  logic [4:0]         inDestReg,
    input  logic               inBranch,
    input  logic               inMemWrite,
    input  logic               inMemRead,
    input  logic               inRegWrite,
    input  logic               inMemToReg,
    mem_access_stage_if.master dmem,
    output logic               stall,
    output logic               pcSrc,
    output logic [31:0]        branchTarget,
    output logic [31:0]        wbReadData,
    output logic [31:0]        wbAluResult,
    output logic [4:0]         wbDestReg,
    output logic               wbRegWrite,
    output logic               wbMemToReg,
    output logic               memErr
);
    state_t            r_state;
    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;

    logic     w_memOp;
    logic     w_done;
    logic     w_timeout;
    logic     w_stall;
    logic     w_rdLoad;
    logic     [31:0] w_rdData;
    wb_ctrl_t w_ctrl;
    wb_ctrl_t w_wbCtrl;

    assign w_memOp = inMemRead | inMemWrite;
    assign w_done  = (r_state == BUSY) & dmem.dmem_ack;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_memErr;

    // fires in the last allowed BUSY cycle; a coincident ack takes priority
    assign w_timeout = (r_state == BUSY) & ~dmem.dmem_ack
                     & (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_memErr <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                r_cnt <= '0;
            end else if (!dmem.dmem_ack) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_memErr <= 1'b1;
            end
        end
    end

    assign memErr = r_memErr;
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign memErr           = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_memOp) begin
                        r_state <= BUSY;
                        r_req   <= 1'b1;
                        r_we    <= inMemWrite;
                        r_addr  <= inAluResult[ADDR_W+1:2];
                        r_wdata <= inWriteData;
                    end
                end
                BUSY: begin
                    if (dmem.dmem_ack || w_timeout) begin
                        r_state <= IDLE;
                        r_req   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign w_stall  = w_memOp & ~w_done & ~w_timeout;
    assign w_rdLoad = (w_done & ~r_we) | w_timeout;
    assign w_rdData = w_timeout ? '0 : dmem.dmem_rdata;
    assign w_ctrl   = w_timeout ? WB_BUBBLE
                                : '{regWrite: inRegWrite, memToReg: inMemToReg};

    mem_wb_reg u_mem_wb_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_stall     (w_stall),
        .i_rdLoad    (w_rdLoad),
        .i_rdData    (w_rdData),
        .i_aluResult (inAluResult),
        .i_destReg   (inDestReg),
        .i_ctrl      (w_ctrl),
        .o_readData  (wbReadData),
        .o_aluResult (wbAluResult),
        .o_destReg   (wbDestReg),
        .o_ctrl      (w_wbCtrl)
    );

    assign wbRegWrite      = w_wbCtrl.regWrite;
    assign wbMemToReg      = w_wbCtrl.memToReg;
    assign stall           = w_stall;
    assign pcSrc           = inBranch & inZeroFlag & ~w_stall;
    assign branchTarget    = inPcBranch;
    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_wdata = r_wdata;
endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage; covers the MEM_TIMEOUT_EN build when that macro is defined.
module tb_mem_access_stage;
    localparam int unsigned AW = 10;
    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inPcBranch, inAluResult, inWriteData;
    logic        inZeroFlag, inBranch, inMemWrite, inMemRead, inRegWrite, inMemToReg;
    logic [4:0]  inDestReg;
    logic        stall, pcSrc, wbRegWrite, wbMemToReg, memErr;
    logic [31:0] branchTarget, wbReadData, wbAluResult;
    logic [4:0]  wbDestReg;

    int          errors = 0;
    int          checks = 0;
    int unsigned cycles = 0;
    logic [31:0] m_rd;   // expected wbReadData (held between completed loads)
    logic        m_err;  // expected memErr

    mem_access_stage_if #(.ADDR_W(AW)) dmem_if ();

    mem_access_stage #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .inPcBranch(inPcBranch), .inZeroFlag(inZeroFlag), .inAluResult(inAluResult),
        .inWriteData(inWriteData), .inDestReg(inDestReg), .inBranch(inBranch),
        .inMemWrite(inMemWrite), .inMemRead(inMemRead), .inRegWrite(inRegWrite),
        .inMemToReg(inMemToReg), .dmem(dmem_if),
        .stall(stall), .pcSrc(pcSrc), .branchTarget(branchTarget),
        .wbReadData(wbReadData), .wbAluResult(wbAluResult), .wbDestReg(wbDestReg),
        .wbRegWrite(wbRegWrite), .wbMemToReg(wbMemToReg), .memErr(memErr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycles <= cycles + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop;
        inMemRead = 1'b0; inMemWrite = 1'b0; inBranch = 1'b0; inZeroFlag = 1'b0;
        inRegWrite = 1'b0; inMemToReg = 1'b0; dmem_if.dmem_ack = 1'b0;
    endtask

    // One EX/MEM instruction; memory answers in BUSY cycle 'lat'. Expectations come from the stage's rules.
    task automatic do_op(input logic rd, input logic wr, input logic rw, input logic m2r,
                         input logic br, input logic zf, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [31:0] pcb, input logic [4:0] dst,
                         input int unsigned lat, input logic [31:0] rdat);
        logic          mop;
        logic          es;
        logic [AW-1:0] ea;
        mop = rd | wr;
        ea  = AW'(alu >> 2);
        inMemRead = rd; inMemWrite = wr; inRegWrite = rw; inMemToReg = m2r;
        inBranch = br; inZeroFlag = zf; inAluResult = alu; inWriteData = wd;
        inPcBranch = pcb; inDestReg = dst;
        dmem_if.dmem_ack = 1'($urandom_range(0, 1));  // an ack while IDLE must be ignored
        dmem_if.dmem_rdata = $urandom();
        #1;
        checks++; if (stall !== mop) begin errors++; $display("FAIL idle_stall: got %b want %b", stall, mop); end
        checks++; if (pcSrc !== (br & zf & ~mop)) begin errors++; $display("FAIL idle_pcSrc: got %b want %b", pcSrc, br & zf & ~mop); end
        checks++; if (branchTarget !== pcb) begin errors++; $display("FAIL branchTarget: got %h want %h", branchTarget, pcb); end
        checks++; if (dmem_if.dmem_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b want 0", dmem_if.dmem_req); end
        tick;
        if (mop) begin
            for (int unsigned k = 1; k <= lat; k++) begin
                dmem_if.dmem_ack   = (k == lat);
                dmem_if.dmem_rdata = (k == lat) ? rdat : $urandom();
                es = (k != lat);
                #1;
                checks++; if (dmem_if.dmem_req !== 1'b1) begin errors++; $display("FAIL busy_req k=%0d: got %b want 1", k, dmem_if.dmem_req); end
                checks++; if (dmem_if.dmem_we !== wr) begin errors++; $display("FAIL busy_we: got %b want %b", dmem_if.dmem_we, wr); end
                checks++; if (dmem_if.dmem_addr !== ea) begin errors++; $display("FAIL busy_addr: got %h want %h", dmem_if.dmem_addr, ea); end
                checks++; if (dmem_if.dmem_wdata !== wd) begin errors++; $display("FAIL busy_wdata: got %h want %h", dmem_if.dmem_wdata, wd); end
                checks++; if (stall !== es) begin errors++; $display("FAIL busy_stall k=%0d: got %b want %b", k, stall, es); end
                checks++; if (pcSrc !== (br & zf & ~es)) begin errors++; $display("FAIL busy_pcSrc: got %b want %b", pcSrc, br & zf & ~es); end
                checks++; if (wbRegWrite !== 1'b0) begin errors++; $display("FAIL bubble_regwrite k=%0d: got %b want 0", k, wbRegWrite); end
                checks++; if (memErr !== m_err) begin errors++; $display("FAIL busy_memErr: got %b want %b", memErr, m_err); end
                tick;
            end
        end
        dmem_if.dmem_ack = 1'b0;
        if (rd && !wr) m_rd = rdat;
        checks++; if (wbRegWrite !== rw) begin errors++; $display("FAIL wb_regwrite: got %b want %b", wbRegWrite, rw); end
        checks++; if (wbMemToReg !== m2r) begin errors++; $display("FAIL wb_memtoreg: got %b want %b", wbMemToReg, m2r); end
        checks++; if (wbAluResult !== alu) begin errors++; $display("FAIL wb_alu: got %h want %h", wbAluResult, alu); end
        checks++; if (wbDestReg !== dst) begin errors++; $display("FAIL wb_dest: got %0d want %0d", wbDestReg, dst); end
        checks++; if (wbReadData !== m_rd) begin errors++; $display("FAIL wb_rdata: got %h want %h", wbReadData, m_rd); end
        checks++; if (dmem_if.dmem_req !== 1'b0) begin errors++; $display("FAIL done_req: got %b want 0", dmem_if.dmem_req); end
    endtask

    task automatic test_reset;
        set_nop;
        inPcBranch = '0; inAluResult = '0; inWriteData = '0; inDestReg = '0;
        dmem_if.dmem_rdata = '0;
        rst_n = 1'b0; inMemRead = 1'b1;
        tick; tick;
        m_rd = '0; m_err = 1'b0;
        checks++; if (dmem_if.dmem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", dmem_if.dmem_req); end
        checks++; if ({wbRegWrite, wbMemToReg} !== 2'b00) begin errors++; $display("FAIL rst_wbctrl: got %b want 00", {wbRegWrite, wbMemToReg}); end
        checks++; if (wbReadData !== 32'h0 || wbAluResult !== 32'h0) begin errors++; $display("FAIL rst_wbdata: got %h/%h want 0/0", wbReadData, wbAluResult); end
        checks++; if (wbDestReg !== 5'd0) begin errors++; $display("FAIL rst_wbdest: got %0d want 0", wbDestReg); end
        checks++; if (memErr !== 1'b0) begin errors++; $display("FAIL rst_memErr: got %b want 0", memErr); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_stall: got %b want 1", stall); end
        inMemRead = 1'b0; rst_n = 1'b1;
        tick;
        checks++; if (dmem_if.dmem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL post_rst: req=%b stall=%b want 0/0", dmem_if.dmem_req, stall); end
    endtask

    task automatic test_load;
        do_op(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h0, 5'd3, 3, 32'hCAFE_F00D);
    endtask

    task automatic test_store;
        do_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0020, 32'h1234_5678, 32'h0, 5'd7, 1, 32'hDEAD_BEEF);
    endtask

    task automatic test_branch;
        set_nop;
        inBranch = 1'b1; inZeroFlag = 1'b1; inPcBranch = 32'h0000_0040;
        #1;
        checks++; if (pcSrc !== 1'b1 || branchTarget !== 32'h40) begin errors++; $display("FAIL br_taken: pcSrc=%b tgt=%h want 1/00000040", pcSrc, branchTarget); end
        inZeroFlag = 1'b0;
        #1;
        checks++; if (pcSrc !== 1'b0) begin errors++; $display("FAIL br_not_taken: got %b want 0", pcSrc); end
        inZeroFlag = 1'b1; inMemRead = 1'b1;
        #1;
        checks++; if (pcSrc !== 1'b0) begin errors++; $display("FAIL br_stalled: got %b want 0", pcSrc); end
        set_nop;
        tick;
    endtask

    task automatic test_back_to_back;
        int unsigned start;
        start = cycles;
        do_op(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h0, 32'h0, 5'd9, 1, 32'h0BAD_F00D);
        do_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0108, 32'h5555_AAAA, 32'h0, 5'd10, 1, 32'h0);
        checks++; if (cycles - start !== 4) begin errors++; $display("FAIL b2b_cycles: got %0d want 4", cycles - start); end
    endtask

    task automatic test_reset_mid;
        set_nop;
        inMemRead = 1'b1; inAluResult = 32'h0000_0044; inRegWrite = 1'b1;
        tick;
        tick;
        rst_n = 1'b0;
        tick;
        m_rd = '0;
        checks++; if (dmem_if.dmem_req !== 1'b0) begin errors++; $display("FAIL midrst_req: got %b want 0", dmem_if.dmem_req); end
        checks++; if (wbRegWrite !== 1'b0 || wbReadData !== 32'h0) begin errors++; $display("FAIL midrst_wb: got %b/%h want 0/0", wbRegWrite, wbReadData); end
        rst_n = 1'b1; set_nop;
        dmem_if.dmem_ack = 1'b1; dmem_if.dmem_rdata = 32'hFFFF_0000;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midrst_stall: got %b want 0", stall); end
        tick;
        dmem_if.dmem_ack = 1'b0;
        checks++; if (dmem_if.dmem_req !== 1'b0 || wbReadData !== 32'h0) begin errors++; $display("FAIL midrst_lateack: req=%b rdata=%h want 0/0", dmem_if.dmem_req, wbReadData); end
        do_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0048, 32'h0, 32'h0, 5'd4, 2, 32'h1357_9BDF);
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            int unsigned op;
            op = $urandom_range(0, 3);
            do_op(op[0], op[1], 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom(), $urandom(), $urandom(), 5'($urandom),
                  $urandom_range(1, TO), $urandom());
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout;
        set_nop;
        inMemRead = 1'b1; inRegWrite = 1'b1; inAluResult = 32'h0000_0080;
        tick;
        for (int unsigned k = 1; k <= TO; k++) begin
            #1;
            checks++; if (stall !== (k < TO)) begin errors++; $display("FAIL to_stall k=%0d: got %b want %b", k, stall, k < TO); end
            tick;
        end
        m_rd = '0; m_err = 1'b1;
        checks++; if (dmem_if.dmem_req !== 1'b0) begin errors++; $display("FAIL to_req: got %b want 0", dmem_if.dmem_req); end
        checks++; if (memErr !== 1'b1) begin errors++; $display("FAIL to_memErr: got %b want 1", memErr); end
        checks++; if (wbRegWrite !== 1'b0 || wbReadData !== 32'h0) begin errors++; $display("FAIL to_wb: got %b/%h want 0/0", wbRegWrite, wbReadData); end
        set_nop;
        tick; tick; tick;
        checks++; if (memErr !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", memErr); end
        do_op(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0090, 32'h0, 32'h0, 5'd12, TO, 32'hA5A5_5A5A);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1; m_err = 1'b0; m_rd = '0;
        checks++; if (memErr !== 1'b0) begin errors++; $display("FAIL to_rst_clear: got %b want 0", memErr); end
    endtask
`else
    task automatic test_no_timeout;
        do_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 32'h0, 32'h0, 5'd15, 24, 32'h2468_ACE0);
        checks++; if (memErr !== 1'b0) begin errors++; $display("FAIL no_to_memErr: got %b want 0", memErr); end
    endtask
`endif

    initial begin
        test_reset;
        test_load;
        test_store;
        test_branch;
        test_back_to_back;
        test_reset_mid;
        test_random;
`ifdef MEM_TIMEOUT_EN
        test_timeout;
`else
        test_no_timeout;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
